bus_decoder: RTL and testbench

BUS_DECODER -- requirements
Module: bus_decoder

---
 rtl/bus_decoder.sv | 197 +++++++++++++++++++
 tb/tb_bus_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_decoder.sv
// Core bus decoder: routes one outstanding request to the to-host register, the RAM window, or an error response.
// Optional RAM ack timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_decoder #(
    parameter logic [31:0] RAM_BASE       = 32'h8000_0000,
    parameter int unsigned RAM_BYTES      = 40000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m_bus_en,
    input  logic        i_m_wr_en,
    input  logic [3:0]  i_m_byte_en,
    input  logic [31:0] i_m_addr,
    input  logic [31:0] i_m_wr_data,
    output logic        o_m_ack,
    output logic [31:0] o_m_rd_data,
    output logic        o_m_err,
    output logic        o_ram_cs,
    output logic        o_ram_wr_en,
    output logic [3:0]  o_ram_b_en,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wr_data,
    input  logic        i_ram_ack,
    input  logic [31:0] i_ram_rd_data,
    output logic [31:0] o_tohost,
    output logic        o_tohost_wr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        ack_r, ack_nxt_s;
    logic        err_r, err_nxt_s;
    logic [31:0] rd_data_r, rd_data_nxt_s;
    logic        ram_cs_r, ram_cs_nxt_s;
    logic        ram_wr_en_r, ram_wr_en_nxt_s;
    logic [3:0]  ram_b_en_r, ram_b_en_nxt_s;
    logic [31:0] ram_addr_r, ram_addr_nxt_s;
    logic [31:0] ram_wr_data_r, ram_wr_data_nxt_s;
    logic [31:0] tohost_r, tohost_nxt_s;
    logic        tohost_wr_r, tohost_wr_nxt_s;
    logic        hit_tohost_s, hit_ram_s, timeout_hit_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode; 33-bit compare keeps the window end from wrapping past 2^32.
    always_comb begin
        hit_tohost_s = (i_m_addr == TOHOST_ADDR);
        hit_ram_s    = ({1'b0, i_m_addr} >= {1'b0, RAM_BASE}) &&
                       ({1'b0, i_m_addr} < ({1'b0, RAM_BASE} + 33'(RAM_BYTES)));
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_r;

    // RAM_WAIT cycle counter, zero whenever the FSM is elsewhere.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            to_cnt_r <= '0;
        end else if (state_r != RAM_WAIT) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + CNT_W'(1);
        end
    end

    assign timeout_hit_s = (state_r == RAM_WAIT) && (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic cfg_unused_s;
    assign cfg_unused_s  = (TIMEOUT_CYCLES != 32'd0);
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_nxt_s       = state_r;
        ack_nxt_s         = 1'b0;
        err_nxt_s         = 1'b0;
        rd_data_nxt_s     = 32'd0;
        ram_cs_nxt_s      = 1'b0;
        ram_wr_en_nxt_s   = 1'b0;
        ram_b_en_nxt_s    = 4'd0;
        ram_addr_nxt_s    = 32'd0;
        ram_wr_data_nxt_s = 32'd0;
        tohost_nxt_s      = tohost_r;
        tohost_wr_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!i_m_bus_en) begin
                    state_nxt_s = IDLE;
                end else if (hit_tohost_s) begin
                    state_nxt_s = RESP;
                    ack_nxt_s   = 1'b1;
                    if (i_m_wr_en) begin
                        tohost_nxt_s    = merge_bytes(tohost_r, i_m_wr_data, i_m_byte_en);
                        tohost_wr_nxt_s = 1'b1;
                    end else begin
                        rd_data_nxt_s = tohost_r;
                    end
                end else if (hit_ram_s) begin
                    state_nxt_s       = RAM_WAIT;
                    ram_cs_nxt_s      = 1'b1;
                    ram_wr_en_nxt_s   = i_m_wr_en;
                    ram_b_en_nxt_s    = i_m_byte_en;
                    ram_addr_nxt_s    = i_m_addr;
                    ram_wr_data_nxt_s = i_m_wr_data;
                end else begin
                    state_nxt_s = RESP;
                    ack_nxt_s   = 1'b1;
                    err_nxt_s   = 1'b1;
                end
            end
            RAM_WAIT: begin
                if (i_ram_ack) begin
                    state_nxt_s   = RESP;
                    ack_nxt_s     = 1'b1;
                    rd_data_nxt_s = i_ram_rd_data;
                end else if (timeout_hit_s) begin
                    state_nxt_s = RESP;
                    ack_nxt_s   = 1'b1;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s       = RAM_WAIT;
                    ram_cs_nxt_s      = 1'b1;
                    ram_wr_en_nxt_s   = ram_wr_en_r;
                    ram_b_en_nxt_s    = ram_b_en_r;
                    ram_addr_nxt_s    = ram_addr_r;
                    ram_wr_data_nxt_s = ram_wr_data_r;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r       <= IDLE;
            ack_r         <= 1'b0;
            err_r         <= 1'b0;
            rd_data_r     <= 32'd0;
            ram_cs_r      <= 1'b0;
            ram_wr_en_r   <= 1'b0;
            ram_b_en_r    <= 4'd0;
            ram_addr_r    <= 32'd0;
            ram_wr_data_r <= 32'd0;
            tohost_r      <= 32'd0;
            tohost_wr_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ack_r         <= ack_nxt_s;
            err_r         <= err_nxt_s;
            rd_data_r     <= rd_data_nxt_s;
            ram_cs_r      <= ram_cs_nxt_s;
            ram_wr_en_r   <= ram_wr_en_nxt_s;
            ram_b_en_r    <= ram_b_en_nxt_s;
            ram_addr_r    <= ram_addr_nxt_s;
            ram_wr_data_r <= ram_wr_data_nxt_s;
            tohost_r      <= tohost_nxt_s;
            tohost_wr_r   <= tohost_wr_nxt_s;
        end
    end

    assign o_m_ack       = ack_r;
    assign o_m_err       = err_r;
    assign o_m_rd_data   = rd_data_r;
    assign o_ram_cs      = ram_cs_r;
    assign o_ram_wr_en   = ram_wr_en_r;
    assign o_ram_b_en    = ram_b_en_r;
    assign o_ram_addr    = ram_addr_r;
    assign o_ram_wr_data = ram_wr_data_r;
    assign o_tohost      = tohost_r;
    assign o_tohost_wr   = tohost_wr_r;

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: directed and random transactions checked against a transaction-level model.
// Define BUS_TIMEOUT_EN for both bench and RTL to exercise the RAM ack timeout.
module tb_bus_decoder;

    localparam logic [31:0] RAM_BASE    = 32'h8000_0000;
    localparam int unsigned RAM_BYTES   = 40000;
    localparam logic [31:0] TOHOST_ADDR = 32'h8000_1000;
    localparam int          TO_CYC      = 16;
    localparam int          BOUND       = 200;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_m_bus_en = 1'b0, i_m_wr_en = 1'b0;
    logic [3:0]  i_m_byte_en = 4'd0;
    logic [31:0] i_m_addr = 32'd0, i_m_wr_data = 32'd0;
    logic        o_m_ack, o_m_err;
    logic [31:0] o_m_rd_data;
    logic        o_ram_cs, o_ram_wr_en;
    logic [3:0]  o_ram_b_en;
    logic [31:0] o_ram_addr, o_ram_wr_data;
    logic        i_ram_ack = 1'b0;
    logic [31:0] i_ram_rd_data = 32'd0;
    logic [31:0] o_tohost;
    logic        o_tohost_wr;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_th = 32'd0;

    bus_decoder #(
        .RAM_BASE(RAM_BASE), .RAM_BYTES(RAM_BYTES),
        .TOHOST_ADDR(TOHOST_ADDR), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m_bus_en(i_m_bus_en), .i_m_wr_en(i_m_wr_en), .i_m_byte_en(i_m_byte_en),
        .i_m_addr(i_m_addr), .i_m_wr_data(i_m_wr_data),
        .o_m_ack(o_m_ack), .o_m_rd_data(o_m_rd_data), .o_m_err(o_m_err),
        .o_ram_cs(o_ram_cs), .o_ram_wr_en(o_ram_wr_en), .o_ram_b_en(o_ram_b_en),
        .o_ram_addr(o_ram_addr), .o_ram_wr_data(o_ram_wr_data),
        .i_ram_ack(i_ram_ack), .i_ram_rd_data(i_ram_rd_data),
        .o_tohost(o_tohost), .o_tohost_wr(o_tohost_wr)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = to-host, 1 = RAM, 2 = unmapped
    function automatic int decode(input logic [31:0] a);
        longint unsigned ua, base, lim;
        ua   = longint'(a);
        base = longint'(RAM_BASE);
        lim  = base + longint'(RAM_BYTES);
        if (a == TOHOST_ADDR) return 0;
        if (ua >= base && ua < lim) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] lane_update(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // ram_lat = RAM_WAIT cycles before the RAM acks; 0 means the RAM never acks.
    task automatic txn(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input int ram_lat, input logic drop_en);
        int kind, exp_lat, exp_cs, cyc, cs_cyc, pulses;
        logic [31:0] ram_rd, exp_rd, exp_th;
        logic exp_err, done;
        kind    = decode(addr);
        ram_rd  = $urandom;
        exp_th  = model_th;
        exp_rd  = 32'd0;
        exp_err = 1'b0;
        exp_cs  = 0;
        exp_lat = 1;
        if (kind == 0) begin
            if (wr) exp_th = lane_update(model_th, wd, be);
            else    exp_rd = model_th;
        end else if (kind == 1) begin
`ifdef BUS_TIMEOUT_EN
            if (ram_lat == 0 || ram_lat > TO_CYC) begin
                exp_lat = TO_CYC + 1;
                exp_cs  = TO_CYC;
                exp_err = 1'b1;
            end else begin
                exp_lat = ram_lat + 1;
                exp_cs  = ram_lat;
                exp_rd  = ram_rd;
            end
`else
            exp_lat = ram_lat + 1;
            exp_cs  = ram_lat;
            exp_rd  = ram_rd;
`endif
        end else begin
            exp_err = 1'b1;
        end

        @(negedge i_clk);
        chk("pre_ack", {31'd0, o_m_ack}, 32'd0);
        i_m_bus_en    = 1'b1;
        i_m_wr_en     = wr;
        i_m_byte_en   = be;
        i_m_addr      = addr;
        i_m_wr_data   = wd;
        i_ram_ack     = (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        i_ram_rd_data = $urandom;
        cyc = 0; cs_cyc = 0; pulses = 0; done = 1'b0;
        while (!done && cyc < BOUND) begin
            @(negedge i_clk);
            cyc++;
            if (drop_en) i_m_bus_en = 1'b0;
            pulses += int'(o_tohost_wr);
            if (o_ram_cs) begin
                cs_cyc++;
                chk("ram_addr", o_ram_addr, addr);
                chk("ram_wr_en", {31'd0, o_ram_wr_en}, {31'd0, wr});
                chk("ram_b_en", {28'd0, o_ram_b_en}, {28'd0, be});
                chk("ram_wr_data", o_ram_wr_data, wd);
            end
            if (o_m_ack) begin
                done = 1'b1;
            end else begin
                chk("err_without_ack", {31'd0, o_m_err}, 32'd0);
                chk("data_without_ack", o_m_rd_data, 32'd0);
            end
            if (kind == 1) begin
                i_ram_ack     = o_ram_cs && (ram_lat != 0) && (cs_cyc == ram_lat);
                i_ram_rd_data = i_ram_ack ? ram_rd : $urandom;
            end else begin
                i_ram_ack     = 1'($urandom_range(0, 1));
                i_ram_rd_data = $urandom;
            end
        end
        chk("ack_seen", {31'd0, done}, 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("m_err", {31'd0, o_m_err}, {31'd0, exp_err});
        chk("m_rd_data", o_m_rd_data, exp_rd);
        chk("ram_cs_cycles", 32'(cs_cyc), 32'(exp_cs));
        chk("tohost", o_tohost, exp_th);
        chk("tohost_wr_pulses", 32'(pulses), (kind == 0 && wr) ? 32'd1 : 32'd0);
        model_th = exp_th;
    endtask

    task automatic idle(input int n);
        i_m_bus_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            chk("idle_ack", {31'd0, o_m_ack}, 32'd0);
            chk("idle_cs", {31'd0, o_ram_cs}, 32'd0);
            chk("idle_tohost_wr", {31'd0, o_tohost_wr}, 32'd0);
            i_ram_ack     = 1'($urandom_range(0, 1));
            i_ram_rd_data = $urandom;
        end
        i_ram_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int          k;
        #2;
        chk("rst_ack", {31'd0, o_m_ack}, 32'd0);
        chk("rst_err", {31'd0, o_m_err}, 32'd0);
        chk("rst_rd_data", o_m_rd_data, 32'd0);
        chk("rst_cs", {31'd0, o_ram_cs}, 32'd0);
        chk("rst_ram_addr", o_ram_addr, 32'd0);
        chk("rst_tohost", o_tohost, 32'd0);
        chk("rst_tohost_wr", {31'd0, o_tohost_wr}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        idle(2);

        txn(1'b1, 4'hF, TOHOST_ADDR, 32'h0000_A5A5, 1, 1'b0);
        chk("tohost_a5a5", o_tohost, 32'h0000_A5A5);
        txn(1'b1, 4'hF, TOHOST_ADDR, 32'h1234_5678, 1, 1'b0);
        txn(1'b1, 4'b0010, TOHOST_ADDR, 32'hFFFF_FFFF, 1, 1'b0);
        chk("tohost_lane1", o_tohost, 32'h1234_FF78);
        txn(1'b1, 4'b0000, TOHOST_ADDR, 32'hDEAD_BEEF, 1, 1'b0);
        txn(1'b0, 4'hF, TOHOST_ADDR, 32'd0, 1, 1'b0);
        txn(1'b0, 4'hF, 32'h8000_0010, 32'd0, 3, 1'b0);
        txn(1'b0, 4'hF, 32'h0000_0000, 32'd0, 1, 1'b0);
        txn(1'b0, 4'hF, RAM_BASE, 32'd0, 1, 1'b0);
        txn(1'b0, 4'hF, RAM_BASE - 32'd1, 32'd0, 1, 1'b0);
        txn(1'b1, 4'b1001, RAM_BASE + RAM_BYTES - 32'd1, 32'hCAFE_F00D, 2, 1'b0);
        txn(1'b1, 4'hF, RAM_BASE + RAM_BYTES, 32'h1111_2222, 2, 1'b0);
        txn(1'b0, 4'hF, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        txn(1'b0, 4'hF, TOHOST_ADDR + 32'd4, 32'd0, 1, 1'b0);
        txn(1'b1, 4'hF, TOHOST_ADDR, 32'h0BAD_F00D, 1, 1'b1);
        txn(1'b0, 4'hF, RAM_BASE + 32'h100, 32'd0, 4, 1'b1);
        idle(3);
`ifdef BUS_TIMEOUT_EN
        txn(1'b0, 4'hF, RAM_BASE + 32'h20, 32'd0, 0, 1'b0);
        idle(4);
        txn(1'b0, 4'hF, RAM_BASE + 32'h24, 32'd0, TO_CYC, 1'b0);
        txn(1'b0, 4'hF, RAM_BASE + 32'h28, 32'd0, TO_CYC + 1, 1'b0);
`else
        txn(1'b0, 4'hF, RAM_BASE + 32'h20, 32'd0, 40, 1'b0);
`endif
        idle(2);

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 2);
            if (k == 0)      ra = TOHOST_ADDR;
            else if (k == 1) ra = RAM_BASE + 32'($urandom_range(0, RAM_BYTES - 1));
            else             ra = $urandom;
`ifdef BUS_TIMEOUT_EN
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom,
                ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6), 1'($urandom_range(0, 1)));
`else
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom,
                $urandom_range(1, 6), 1'($urandom_range(0, 1)));
`endif
        end
        idle(2);

        txn(1'b1, 4'hF, TOHOST_ADDR, 32'hCAFE_0001, 1, 1'b0);
        idle(1);
        @(negedge i_clk);
        i_m_bus_en  = 1'b1;
        i_m_wr_en   = 1'b0;
        i_m_byte_en = 4'hF;
        i_m_addr    = RAM_BASE + 32'h40;
        i_ram_ack   = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("pre_reset_cs", {31'd0, o_ram_cs}, 32'd1);
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_rst_cs", {31'd0, o_ram_cs}, 32'd0);
        chk("async_rst_tohost", o_tohost, 32'd0);
        chk("async_rst_ack", {31'd0, o_m_ack}, 32'd0);
        model_th   = 32'd0;
        i_m_bus_en = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        idle(6);
        txn(1'b0, 4'hF, TOHOST_ADDR, 32'd0, 1, 1'b0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
